// File: rtl/ppi_control_unit.sv
// Control and sequencing for the PPI port slices: bus-cycle decode, control word,
// output latches, port C bit set/reset and per-slice direction/enable generation.
module ppi_control_unit #(
   parameter logic [7:0] CTRL_RESET = 8'h9B
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cs_n,
   input  logic       rd_n,
   input  logic       wr_n,
   input  logic [1:0] addr,
   input  logic [7:0] din,
   output logic [7:0] ctrl_word,
   output logic       mode_a,
   output logic       mode_b,
   output logic       mode_cu,
   output logic       mode_cl,
   output logic       en_a,
   output logic       en_b,
   output logic       en_c,
   output logic [7:0] out_a,
   output logic [7:0] out_b,
   output logic [7:0] out_c,
   output logic       wr_ack,
   output logic       mode_err
);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_COMMIT} state_t;

   state_t      state_q, state_d;
   logic        cs_q, rd_q, wr_q;
   logic [1:0]  addr_q;
   logic [7:0]  din_q;
   logic [1:0]  rd_addr_q, rd_addr_d;
   logic [1:0]  wr_addr_q, wr_addr_d;
   logic [7:0]  wr_data_q, wr_data_d;
   logic [7:0]  ctrl_q, ctrl_d;
   logic [7:0]  out_a_q, out_a_d;
   logic [7:0]  out_b_q, out_b_d;
   logic [7:0]  out_c_q, out_c_d;
   logic        err_q, err_d;
   logic        commit;

   // Bus strobes are registered once; every decision below uses these copies.
   // NOTE: sequential state uses <= so all registers see pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cs_q   <= 1'b1;
         rd_q   <= 1'b1;
         wr_q   <= 1'b1;
         addr_q <= 2'd0;
         din_q  <= 8'd0;
      end else begin
         cs_q   <= cs_n;
         rd_q   <= rd_n;
         wr_q   <= wr_n;
         addr_q <= addr;
         din_q  <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (!cs_q && !rd_q && wr_q && addr_q != 2'd3) state_d = S_READ;
            else if (!cs_q && !wr_q && rd_q)              state_d = S_WRITE;
         end
         S_READ:   if (rd_q || cs_q)           state_d = S_IDLE;
         S_WRITE:  if (rd_q && (wr_q || cs_q)) state_d = S_COMMIT;
         S_COMMIT: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      wr_ack = (state_q == S_COMMIT);
      en_a   = (state_q == S_READ) && (rd_addr_q == 2'd0) && mode_a;
      en_b   = (state_q == S_READ) && (rd_addr_q == 2'd1) && mode_b;
      en_c   = (state_q == S_READ) && (rd_addr_q == 2'd2) && (mode_cu || mode_cl);
   end

   // Write effects land on the edge entering COMMIT, so they are visible with wr_ack.
   assign commit = (state_q == S_WRITE) && (state_d == S_COMMIT);

   always_comb begin
      rd_addr_d = rd_addr_q;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      ctrl_d    = ctrl_q;
      out_a_d   = out_a_q;
      out_b_d   = out_b_q;
      out_c_d   = out_c_q;
      err_d     = err_q;
      if (state_q == S_IDLE && state_d == S_READ) rd_addr_d = addr_q;
      if (state_d == S_WRITE) begin
         wr_addr_d = addr_q;
         wr_data_d = din_q;
      end
      if (commit) begin
         case (wr_addr_q)
            2'd0: if (!ctrl_q[4]) out_a_d = wr_data_q;
            2'd1: if (!ctrl_q[1]) out_b_d = wr_data_q;
            2'd2: begin
               if (!ctrl_q[3]) out_c_d[7:4] = wr_data_q[7:4];
               if (!ctrl_q[0]) out_c_d[3:0] = wr_data_q[3:0];
            end
            default: begin
               if (wr_data_q[7]) begin
                  ctrl_d  = wr_data_q;
                  out_a_d = 8'd0;
                  out_b_d = 8'd0;
                  out_c_d = 8'd0;
                  if (wr_data_q[6:5] != 2'd0 || wr_data_q[2]) err_d = 1'b1;
               end else begin
                  // Bit set/reset ignores the direction of port C.
                  out_c_d[wr_data_q[3:1]] = wr_data_q[0];
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_addr_q <= 2'd0;
         wr_addr_q <= 2'd0;
         wr_data_q <= 8'd0;
         ctrl_q    <= CTRL_RESET;
         out_a_q   <= 8'd0;
         out_b_q   <= 8'd0;
         out_c_q   <= 8'd0;
         err_q     <= 1'b0;
      end else begin
         rd_addr_q <= rd_addr_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         ctrl_q    <= ctrl_d;
         out_a_q   <= out_a_d;
         out_b_q   <= out_b_d;
         out_c_q   <= out_c_d;
         err_q     <= err_d;
      end
   end

   assign ctrl_word = ctrl_q;
   assign mode_a    = ctrl_q[4];
   assign mode_cu   = ctrl_q[3];
   assign mode_b    = ctrl_q[1];
   assign mode_cl   = ctrl_q[0];
   assign out_a     = out_a_q;
   assign out_b     = out_b_q;
   assign out_c     = out_c_q;
   assign mode_err  = err_q;

endmodule

// File: tb/tb_ppi_control_unit.sv
// Self-checking bench for ppi_control_unit: directed scenarios plus random bus
// transactions checked against a transaction-level model of the PPI registers.
module tb_ppi_control_unit;

   logic       clk = 1'b0;
   logic       rst_n, cs_n, rd_n, wr_n;
   logic [1:0] addr;
   logic [7:0] din;
   logic [7:0] ctrl_word, out_a, out_b, out_c;
   logic       mode_a, mode_b, mode_cu, mode_cl;
   logic       en_a, en_b, en_c, wr_ack, mode_err;

   int n_checks = 0;
   int n_fail   = 0;

   // Transaction-level model of the architectural registers.
   logic [7:0] m_ctrl, m_a, m_b, m_c;
   logic       m_err;

   ppi_control_unit dut (
      .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n),
      .addr(addr), .din(din), .ctrl_word(ctrl_word),
      .mode_a(mode_a), .mode_b(mode_b), .mode_cu(mode_cu), .mode_cl(mode_cl),
      .en_a(en_a), .en_b(en_b), .en_c(en_c),
      .out_a(out_a), .out_b(out_b), .out_c(out_c),
      .wr_ack(wr_ack), .mode_err(mode_err)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_ctrl = 8'h9B;
      m_a = 8'h00; m_b = 8'h00; m_c = 8'h00;
      m_err = 1'b0;
   endtask

   task automatic model_write(input logic [1:0] a, input logic [7:0] d);
      case (a)
         2'd0: if (!m_ctrl[4]) m_a = d;
         2'd1: if (!m_ctrl[1]) m_b = d;
         2'd2: m_c = {m_ctrl[3] ? m_c[7:4] : d[7:4], m_ctrl[0] ? m_c[3:0] : d[3:0]};
         default: begin
            if (d[7]) begin
               m_ctrl = d;
               m_a = 8'h00; m_b = 8'h00; m_c = 8'h00;
               if (d[6:5] != 2'b00 || d[2]) m_err = 1'b1;
            end else begin
               m_c[d[3:1]] = d[0];
            end
         end
      endcase
   endtask

   task automatic apply_reset();
      @(posedge clk); #1;
      rst_n = 1'b0; cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   // Full write cycle with wr_n low for n cycles; checks the ack pulse timing and final registers.
   task automatic bus_write(input logic [1:0] a, input logic [7:0] d, input int n);
      logic [3:0]  exp_sig;
      logic [40:0] exp_regs;
      addr = a; din = d; rd_n = 1'b1;
      for (int c = 0; c <= n + 4; c++) begin
         @(posedge clk); #1;
         cs_n = (c < n) ? 1'b0 : 1'b1;
         wr_n = (c < n) ? 1'b0 : 1'b1;
         @(negedge clk);
         exp_sig = {(c == n + 2), 3'b000};
         n_checks++;
         if ({wr_ack, en_a, en_b, en_c} !== exp_sig) begin
            n_fail++;
            $display("FAIL write_ack a=%0d d=%h c=%0d: ack/en got %b want %b", a, d, c,
                     {wr_ack, en_a, en_b, en_c}, exp_sig);
         end
      end
      model_write(a, d);
      exp_regs = {m_ctrl, m_a, m_b, m_c, m_err, m_ctrl[4], m_ctrl[1], m_ctrl[3], m_ctrl[0]};
      n_checks++;
      if ({ctrl_word, out_a, out_b, out_c, mode_err, mode_a, mode_b, mode_cu, mode_cl} !== exp_regs) begin
         n_fail++;
         $display("FAIL write_regs a=%0d d=%h: got %h want %h", a, d,
                  {ctrl_word, out_a, out_b, out_c, mode_err, mode_a, mode_b, mode_cu, mode_cl}, exp_regs);
      end
   endtask

   // Read cycle with rd_n low for n cycles; enables must follow rd_n two clocks late.
   task automatic bus_read(input logic [1:0] a, input int n);
      logic [3:0]  exp_sig;
      logic        win;
      logic [40:0] exp_regs;
      addr = a; wr_n = 1'b1; din = 8'($urandom);
      for (int c = 0; c <= n + 3; c++) begin
         @(posedge clk); #1;
         cs_n = (c < n) ? 1'b0 : 1'b1;
         rd_n = (c < n) ? 1'b0 : 1'b1;
         @(negedge clk);
         win = (c >= 2) && (c <= n + 1);
         exp_sig = {1'b0, win && a == 2'd0 && m_ctrl[4], win && a == 2'd1 && m_ctrl[1],
                    win && a == 2'd2 && (m_ctrl[3] || m_ctrl[0])};
         n_checks++;
         if ({wr_ack, en_a, en_b, en_c} !== exp_sig) begin
            n_fail++;
            $display("FAIL read_en a=%0d c=%0d: ack/en got %b want %b", a, c,
                     {wr_ack, en_a, en_b, en_c}, exp_sig);
         end
      end
      exp_regs = {m_ctrl, m_a, m_b, m_c, m_err, m_ctrl[4], m_ctrl[1], m_ctrl[3], m_ctrl[0]};
      n_checks++;
      if ({ctrl_word, out_a, out_b, out_c, mode_err, mode_a, mode_b, mode_cu, mode_cl} !== exp_regs) begin
         n_fail++;
         $display("FAIL read_regs a=%0d: got %h want %h", a,
                  {ctrl_word, out_a, out_b, out_c, mode_err, mode_a, mode_b, mode_cu, mode_cl}, exp_regs);
      end
   endtask

   task automatic test_reset();
      apply_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({ctrl_word, mode_a, mode_b, mode_cu, mode_cl} !== {8'h9B, 4'b1111}) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %h/%b want 9b/1111", ctrl_word, {mode_a, mode_b, mode_cu, mode_cl});
      end
      n_checks++;
      if ({out_a, out_b, out_c, en_a, en_b, en_c, wr_ack, mode_err} !== 29'd0) begin
         n_fail++;
         $display("FAIL reset_outs: got %h want 0", {out_a, out_b, out_c, en_a, en_b, en_c, wr_ack, mode_err});
      end
   endtask

   task automatic test_mode0_output();
      bus_write(2'd3, 8'h80, 1);
      bus_write(2'd0, 8'h5A, 2);
      n_checks++;
      if ({ctrl_word, out_a} !== {8'h80, 8'h5A}) begin
         n_fail++;
         $display("FAIL mode0_out: got %h want 805a", {ctrl_word, out_a});
      end
      bus_read(2'd0, 3);
   endtask

   task automatic test_read_enable();
      bus_write(2'd3, 8'h90, 1);
      bus_read(2'd0, 4);
      bus_read(2'd1, 2);
      bus_read(2'd2, 2);
      bus_read(2'd3, 2);
      bus_write(2'd3, 8'h9B, 1);
      bus_read(2'd2, 1);
      bus_read(2'd1, 3);
   endtask

   task automatic test_port_c();
      bus_write(2'd3, 8'h81, 1);
      bus_write(2'd2, 8'hF5, 2);
      n_checks++;
      if (out_c !== 8'hF0) begin
         n_fail++;
         $display("FAIL portc_half: got %h want f0", out_c);
      end
      bus_write(2'd3, 8'h07, 1);
      n_checks++;
      if (out_c !== 8'hF8) begin
         n_fail++;
         $display("FAIL portc_bsr_set: got %h want f8", out_c);
      end
      bus_write(2'd3, 8'h0E, 3);
      n_checks++;
      if ({out_c, ctrl_word} !== {8'h78, 8'h81}) begin
         n_fail++;
         $display("FAIL portc_bsr_clr: got %h want 7881", {out_c, ctrl_word});
      end
   endtask

   task automatic test_mode_err();
      bus_write(2'd3, 8'hA4, 1);
      n_checks++;
      if ({mode_err, ctrl_word} !== {1'b1, 8'hA4}) begin
         n_fail++;
         $display("FAIL mode_err_set: got %h want 1a4", {mode_err, ctrl_word});
      end
      bus_write(2'd3, 8'h80, 1);
      n_checks++;
      if (mode_err !== 1'b1) begin
         n_fail++;
         $display("FAIL mode_err_sticky: got %b want 1", mode_err);
      end
      apply_reset();
      @(negedge clk);
      n_checks++;
      if (mode_err !== 1'b0) begin
         n_fail++;
         $display("FAIL mode_err_clear: got %b want 0", mode_err);
      end
   endtask

   task automatic test_both_strobes();
      bus_write(2'd3, 8'h80, 1);
      addr = 2'd0; din = 8'hC3;
      for (int c = 0; c < 7; c++) begin
         @(posedge clk); #1;
         cs_n = (c < 3) ? 1'b0 : 1'b1;
         rd_n = (c < 3) ? 1'b0 : 1'b1;
         wr_n = (c < 3) ? 1'b0 : 1'b1;
         @(negedge clk);
         n_checks++;
         if ({wr_ack, en_a, en_b, en_c, out_a} !== {4'b0000, m_a}) begin
            n_fail++;
            $display("FAIL both_strobes c=%0d: got %h want %h", c,
                     {wr_ack, en_a, en_b, en_c, out_a}, {4'b0000, m_a});
         end
      end
   endtask

   task automatic test_reset_mid_write();
      bus_write(2'd3, 8'h80, 1);
      addr = 2'd0; din = 8'hFF; rd_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         cs_n = 1'b0; wr_n = 1'b0;
      end
      @(posedge clk); #1;
      rst_n = 1'b0; cs_n = 1'b1; wr_n = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_reset();
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         n_checks++;
         if ({wr_ack, out_a, ctrl_word} !== {1'b0, 8'h00, 8'h9B}) begin
            n_fail++;
            $display("FAIL reset_mid_write c=%0d: got %h want 0009b", c, {wr_ack, out_a, ctrl_word});
         end
      end
      bus_write(2'd3, 8'h80, 1);
      bus_write(2'd0, 8'h33, 2);
   endtask

   task automatic test_random();
      logic [1:0] a;
      logic [7:0] d;
      for (int t = 0; t < 60; t++) begin
         a = 2'($urandom);
         d = 8'($urandom);
         if ($urandom_range(0, 19) == 0) apply_reset();
         if ($urandom_range(0, 1) == 0) begin
            if (a == 2'd3 && $urandom_range(0, 1) == 0) d[7] = 1'b1;
            bus_write(a, d, $urandom_range(1, 3));
         end else begin
            bus_read(a, $urandom_range(1, 4));
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
      addr = 2'd0; din = 8'h00;
      model_reset();
      test_reset();
      test_mode0_output();
      test_read_enable();
      test_port_c();
      test_mode_err();
      test_both_strobes();
      test_reset_mid_write();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ppi_control_unit.md
Name: ppi_control_unit

Overview:
- Control/sequencing block for the 8-bit PPI port slices (port A, port B, port C).
- Decodes CPU bus cycles (cs_n/rd_n/wr_n/addr), holds the control word register and the output latches, and handles port C bit set/reset.
- Generates per-port direction and enable signals consumed by each port8 slice.
- Mode 0 (basic I/O) only; requests for modes 1/2 are recorded and flagged.

Parameters:
- CTRL_RESET, 8'h9B, control word loaded at reset (all ports input, mode 0).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- cs_n  in  1  chip select, active low
- rd_n  in  1  read strobe, active low
- wr_n  in  1  write strobe, active low
- addr  in  2  0=A, 1=B, 2=C, 3=control
- din  in  8  write data from databus
- ctrl_word  out  8  current control word
- mode_a  out  1  port A direction (1=input: port drives databus, 0=output)
- mode_b  out  1  port B direction
- mode_cu  out  1  port C[7:4] direction
- mode_cl  out  1  port C[3:0] direction
- en_a, en_b, en_c  out  1 each  port-to-databus transfer enable for the slice
- out_a, out_b, out_c  out  8 each  output latches
- wr_ack  out  1  one-cycle pulse when a write commits
- mode_err  out  1  sticky flag: unsupported mode requested

Behaviour:
- Bus inputs are synchronous to clk; one register stage is applied. All decisions use the registered values.
- Reset (rst_n=0 at clk edge):
  - ctrl_word=CTRL_RESET
  - out_a, out_b, out_c = 0
  - en_* = 0, wr_ack = 0, mode_err = 0
  - FSM = IDLE
  - Reset mid-cycle aborts the cycle; no commit.
- Direction decode is combinational from ctrl_word: mode_a=[4], mode_cu=[3], mode_b=[1], mode_cl=[0].
- FSM states: IDLE, READ, WRITE, COMMIT.
- IDLE:
  - cs_n=0, rd_n=0, wr_n=1, addr!=3 -> READ.
  - cs_n=0, wr_n=0, rd_n=1 -> WRITE.
  - rd_n and wr_n both low -> stay IDLE; no action.
  - Read of addr 3 -> stay IDLE; no enable.
- READ:
  - Addressed en_x=1 from the first cycle in READ, if that port is input.
  - en_c=1 if mode_cu or mode_cl is 1.
  - A read of an output-direction port asserts no enable.
  - addr is latched on entry.
  - Exit to IDLE when rd_n=1 or cs_n=1; en_* is 0 in the same cycle the exit is registered.
- WRITE:
  - addr and din are captured every cycle; the last captured value is used.
  - On rd_n=1 with wr_n=1 or cs_n=1 -> COMMIT.
- COMMIT lasts exactly one cycle, sets wr_ack=1, then -> IDLE. Write actions:
  - addr 0: out_a=din if mode_a=0, otherwise discarded.
  - addr 1: out_b=din if mode_b=0, otherwise discarded.
  - addr 2: out_c[7:4] updated if mode_cu=0; out_c[3:0] updated if mode_cl=0; input halves unchanged.
  - addr 3 with din[7]=1 (mode set):
    - ctrl_word=din; out_a, out_b, out_c cleared to 0.
    - mode_err set if din[6:5]!=0 or din[2]!=0.
    - The word is stored as written; direction bits still apply.
  - addr 3 with din[7]=0 (bit set/reset): out_c[din[3:1]]=din[0] regardless of C direction; ctrl_word unchanged.
  - wr_ack pulses for all writes, including discarded ones.
- mode_err clears only on reset.
- Latency: en_* asserts 2 clk after rd_n falls (sync plus state). A write commits 2 clk after wr_n rises.

Test Plan:
- Reset then idle -> ctrl_word=8'h9B; mode_a/b/cu/cl=1; out_*=0; en_*=0; wr_ack=0.
- Write addr3 din=8'h80, then addr0 din=8'h5A -> ctrl_word=8'h80, all modes 0, out_a=8'h5A, wr_ack one pulse per write; read addr0 -> en_a stays 0.
- Control 8'h90 (A input), read addr0 held 4 cycles -> en_a=1 for the cycles rd_n low after 2-cycle latency; drops the cycle after rd_n rises; en_b/en_c=0.
- Control 8'h81 (C low input), write addr2 din=8'hF5 -> out_c=8'hF0; then BSR din=8'h07 -> out_c=8'hF8; then BSR din=8'h0E -> out_c=8'h78.
- Mode set din=8'hA4 -> mode_err=1, ctrl_word=8'hA4; a later 8'h80 leaves mode_err=1; rst_n low one cycle clears it.
- Assert rst_n=0 while in WRITE (wr_n low, addr0, din=8'hFF) -> no wr_ack, out_a stays 0, FSM IDLE after release.
